// File: rtl/nfu_pkg.sv
// Shared types, widths, normal factors and the shift/saturate helper
// for the payload normalisation scheduler.
package nfu_pkg;

  localparam int DI_W   = 12;
  localparam int FACT_W = 14;
  localparam int DO_W   = 14;
  localparam int FRAC   = 10;
  localparam int PROD_W = DI_W + FACT_W;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_16QAM = 2'd2,
    MOD_64QAM = 2'd3
  } mod_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC    = 2'd1,
    ST_MUL_IM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam logic [FACT_W-1:0] FACT_BPSK  = 14'd1024;
  localparam logic [FACT_W-1:0] FACT_QPSK  = 14'd1448;
  localparam logic [FACT_W-1:0] FACT_16QAM = 14'd3238;
  localparam logic [FACT_W-1:0] FACT_64QAM = 14'd6636;

  localparam logic signed [PROD_W-1:0] SAT_HI = 26'sd8191;
  localparam logic signed [PROD_W-1:0] SAT_LO = -26'sd8192;

  function automatic logic [FACT_W-1:0] factor_of(input logic [1:0] mod);
    case (mod_e'(mod))
      MOD_BPSK:  return FACT_BPSK;
      MOD_QPSK:  return FACT_QPSK;
      MOD_16QAM: return FACT_16QAM;
      MOD_64QAM: return FACT_64QAM;
      default:   return FACT_BPSK;
    endcase
  endfunction

  // Arithmetic shift floors toward -inf before clamping to the output range.
  function automatic logic signed [DO_W-1:0] norm_sat(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] s;
    s = p >>> FRAC;
    if (s > SAT_HI) begin
      return SAT_HI[DO_W-1:0];
    end else if (s < SAT_LO) begin
      return SAT_LO[DO_W-1:0];
    end else begin
      return s[DO_W-1:0];
    end
  endfunction

endpackage

// File: rtl/nfu_shared_mult.sv
// 12x14 signed multiplier with two register stages, time-shared between
// the real and imaginary part of each sample.
module nfu_shared_mult
  import nfu_pkg::*;
(
  input  logic                     clk,
  input  logic                     clr,
  input  logic signed [DI_W-1:0]   a_i,
  input  logic signed [FACT_W-1:0] b_i,
  output logic signed [PROD_W-1:0] p_o
);

  logic signed [PROD_W-1:0] a_ext_s;
  logic signed [PROD_W-1:0] b_ext_s;
  logic signed [PROD_W-1:0] p1_q;

  assign a_ext_s = {{(PROD_W-DI_W){a_i[DI_W-1]}}, a_i};
  assign b_ext_s = {{(PROD_W-FACT_W){b_i[FACT_W-1]}}, b_i};

  // Product stage followed by an output stage; cleared synchronously.
  always_ff @(posedge clk) begin
    if (clr) begin
      p1_q <= '0;
      p_o  <= '0;
    end else begin
      p1_q <= a_ext_s * b_ext_s;
      p_o  <= p1_q;
    end
  end

endmodule

// File: rtl/nfu_sched.sv
// Frame scheduler: latches modulation/length, feeds re then im of each
// sample through the shared multiplier and emits saturated results.
module nfu_sched
  import nfu_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frm_start_i,
  input  logic [1:0]             mod_type_i,
  input  logic [LEN_W-1:0]       frm_len_i,
  input  logic signed [DI_W-1:0] di_re_i,
  input  logic signed [DI_W-1:0] di_im_i,
  input  logic                   di_vld_i,
  output logic                   di_rdy_o,
  output logic signed [DO_W-1:0] do_re_o,
  output logic signed [DO_W-1:0] do_im_o,
  output logic                   do_vld_o,
  output logic                   do_last_o,
  output logic                   busy_o,
  output logic                   err_o
);

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [FACT_W-1:0]        fact_q, fact_d;
  logic signed [DI_W-1:0]   op_q, op_d;
  logic signed [DI_W-1:0]   im_hold_q, im_hold_d;
  logic signed [PROD_W-1:0] re_hold_q;
  logic signed [PROD_W-1:0] prod_s;
  logic [3:0]               tok_q;
  logic [3:0]               lst_q;
  logic                     accept_s;
  logic                     err_d;

  assign accept_s = (state_q == ST_ACC) && di_vld_i;

  nfu_shared_mult u_mult (
    .clk (clk),
    .clr (rst),
    .a_i (op_q),
    .b_i ($signed(fact_q)),
    .p_o (prod_s)
  );

  // Next-state, configuration latch and multiplier operand selection.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    fact_d    = fact_q;
    op_d      = op_q;
    im_hold_d = im_hold_q;
    err_d     = frm_start_i && ((state_q != ST_IDLE) || (frm_len_i == '0));
    case (state_q)
      ST_IDLE: begin
        if (frm_start_i && (frm_len_i != '0)) begin
          state_d = ST_ACC;
          len_d   = frm_len_i;
          fact_d  = factor_of(mod_type_i);
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (accept_s) begin
          op_d      = di_re_i;
          im_hold_d = di_im_i;
          cnt_d     = cnt_q + LEN_W'(1);
          state_d   = ST_MUL_IM;
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_MUL_IM: begin
        op_d = im_hold_q;
        if (cnt_q == len_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DRAIN: begin
        if (tok_q[3] && lst_q[3]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, token pipeline and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      fact_q    <= '0;
      op_q      <= '0;
      im_hold_q <= '0;
      re_hold_q <= '0;
      tok_q     <= '0;
      lst_q     <= '0;
      di_rdy_o  <= 1'b0;
      do_re_o   <= '0;
      do_im_o   <= '0;
      do_vld_o  <= 1'b0;
      do_last_o <= 1'b0;
      busy_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      fact_q    <= fact_d;
      op_q      <= op_d;
      im_hold_q <= im_hold_d;
      // Token k marks the re operand's position k edges after acceptance.
      tok_q     <= {tok_q[2:0], accept_s};
      lst_q     <= {lst_q[2:0], accept_s && ((cnt_q + LEN_W'(1)) == len_q)};
      if (tok_q[2]) begin
        re_hold_q <= prod_s;
      end
      if (tok_q[3]) begin
        do_re_o <= norm_sat(re_hold_q);
        do_im_o <= norm_sat(prod_s);
      end
      do_vld_o  <= tok_q[3];
      do_last_o <= tok_q[3] && lst_q[3];
      di_rdy_o  <= (state_d == ST_ACC);
      busy_o    <= (state_d != ST_IDLE);
      err_o     <= err_d;
    end
  end

endmodule

// File: tb/tb_nfu_sched.sv
// Directed bench for nfu_sched: single-sample vector table plus
// hand-written multi-sample, error and reset sequences.
module tb_nfu_sched;

  logic              clk = 1'b0;
  logic              rst;
  logic              frm_start;
  logic [1:0]        mod_type;
  logic [9:0]        frm_len;
  logic signed [11:0] di_re, di_im;
  logic              di_vld;
  logic              di_rdy;
  logic signed [13:0] do_re, do_im;
  logic              do_vld, do_last, busy, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic signed [13:0] re;
    logic signed [13:0] im;
    logic               last;
    int                 c;
  } out_t;
  out_t oq[$];

  typedef struct {
    logic [1:0] m;
    int re, im, ere, eim;
  } vec_t;

  nfu_sched #(.LEN_W(10)) dut (
    .clk(clk), .rst(rst), .frm_start_i(frm_start), .mod_type_i(mod_type),
    .frm_len_i(frm_len), .di_re_i(di_re), .di_im_i(di_im), .di_vld_i(di_vld),
    .di_rdy_o(di_rdy), .do_re_o(do_re), .do_im_o(do_im), .do_vld_o(do_vld),
    .do_last_o(do_last), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (do_vld) oq.push_back('{do_re, do_im, do_last, cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic start_frame(input logic [1:0] m, input logic [9:0] len);
    frm_start = 1'b1;
    mod_type  = m;
    frm_len   = len;
    @(posedge clk); #1;
    frm_start = 1'b0;
  endtask

  task automatic send(input int re, input int im, output int acc);
    logic rdy;
    acc    = -1;
    di_re  = re[11:0];
    di_im  = im[11:0];
    di_vld = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rdy = di_rdy;
      @(posedge clk); #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    di_vld = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic check_out(input string nm, input int ere, input int eim,
                           input int elast, input int acc);
    out_t o;
    if (oq.size() == 0) begin
      chk({nm, "_missing"}, 0, 1);
    end else begin
      o = oq.pop_front();
      chk({nm, "_re"}, int'(o.re), ere);
      chk({nm, "_im"}, int'(o.im), eim);
      chk({nm, "_last"}, int'(o.last), elast);
      chk({nm, "_latency"}, o.c - acc, 4);
    end
  endtask

  initial begin
    vec_t vt[10];
    int   acc, a0, a1;
    int   bacc[4];
    int   bre[4];
    int   bim[4];

    vt[0] = '{2'd2,   100,  -100,   316,  -317};
    vt[1] = '{2'd3,  2047, -2048,  8191, -8192};
    vt[2] = '{2'd1,     1,    -1,     1,    -2};
    vt[3] = '{2'd0, -2048,  2047, -2048,  2047};
    vt[4] = '{2'd3,     1,    -1,     6,    -7};
    vt[5] = '{2'd2, -2048,     0, -6476,     0};
    vt[6] = '{2'd1,  2047, -2047,  2894, -2895};
    vt[7] = '{2'd3,  1235, -1234,  8003, -7997};
    vt[8] = '{2'd3,  1264, -1264,  8191, -8192};
    vt[9] = '{2'd3,  1265, -1265,  8191, -8192};

    rst = 1'b1; frm_start = 1'b0; mod_type = 2'd0; frm_len = 10'd0;
    di_re = 12'sd0; di_im = 12'sd0; di_vld = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_do_vld", int'(do_vld), 0);
    chk("rst_do_last", int'(do_last), 0);
    chk("rst_do_re", int'(do_re), 0);
    chk("rst_do_im", int'(do_im), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_di_rdy", int'(di_rdy), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-sample frames from the table.
    for (int i = 0; i < 10; i++) begin
      start_frame(vt[i].m, 10'd1);
      send(vt[i].re, vt[i].im, acc);
      repeat (6) @(posedge clk); #2;
      chk($sformatf("vec%0d_count", i), oq.size(), 1);
      check_out($sformatf("vec%0d", i), vt[i].ere, vt[i].eim, 1, acc);
      chk($sformatf("vec%0d_busy_low", i), int'(busy), 0);
      oq.delete();
    end

    // QPSK two-sample frame, back-to-back accepts two cycles apart.
    start_frame(2'd1, 10'd2);
    send(1, -1, a0);
    send(0, 5, a1);
    chk("qpsk_accept_gap", a1 - a0, 2);
    repeat (8) @(posedge clk); #2;
    chk("qpsk_count", oq.size(), 2);
    check_out("qpsk_s0", 1, -2, 0, a0);
    check_out("qpsk_s1", 0, 7, 1, a1);
    chk("qpsk_busy_low", int'(busy), 0);
    oq.delete();

    // BPSK four samples with di_vld held high: di_rdy alternates.
    bre = '{5, 100, -300, 2047};
    bim = '{-5, 200, 7, -2048};
    start_frame(2'd0, 10'd4);
    di_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bpsk_rdy_c%0d", i), int'(di_rdy), (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) begin
        di_re = bre[i/2][11:0];
        di_im = bim[i/2][11:0];
        bacc[i/2] = cyc + 1;
      end
      @(posedge clk); #1;
    end
    di_vld = 1'b0;
    repeat (6) @(posedge clk); #2;
    chk("bpsk_count", oq.size(), 4);
    for (int k = 0; k < 4; k++)
      check_out($sformatf("bpsk_s%0d", k), bre[k], bim[k], (k == 3) ? 1 : 0, bacc[k]);
    oq.delete();

    // Zero-length frame request.
    frm_start = 1'b1; frm_len = 10'd0; mod_type = 2'd1;
    @(posedge clk); #1;
    frm_start = 1'b0;
    chk("len0_err", int'(err), 1);
    chk("len0_busy", int'(busy), 0);
    chk("len0_rdy", int'(di_rdy), 0);
    @(posedge clk); #1;
    chk("len0_err_pulse", int'(err), 0);
    chk("len0_busy_after", int'(busy), 0);

    // frm_start mid-frame: flagged and ignored.
    start_frame(2'd2, 10'd2);
    send(100, -100, a0);
    frm_start = 1'b1; frm_len = 10'd1; mod_type = 2'd0;
    @(posedge clk); #1;
    frm_start = 1'b0;
    chk("mid_err", int'(err), 1);
    chk("mid_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("mid_err_pulse", int'(err), 0);
    send(100, -100, a1);
    repeat (8) @(posedge clk); #2;
    chk("mid_count", oq.size(), 2);
    check_out("mid_s0", 316, -317, 0, a0);
    check_out("mid_s1", 316, -317, 1, a1);
    chk("mid_busy_low", int'(busy), 0);
    oq.delete();

    // Reset in MUL_IM of a 3-sample frame.
    start_frame(2'd2, 10'd3);
    send(100, -100, a0);
    rst = 1'b1;
    #1;
    chk("mrst_do_re", int'(do_re), 0);
    chk("mrst_do_im", int'(do_im), 0);
    chk("mrst_do_vld", int'(do_vld), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_di_rdy", int'(di_rdy), 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk); #2;
    chk("mrst_no_output", oq.size(), 0);
    chk("mrst_busy_after", int'(busy), 0);
    oq.delete();
    start_frame(2'd2, 10'd1);
    send(100, -100, acc);
    repeat (6) @(posedge clk); #2;
    chk("post_rst_count", oq.size(), 1);
    check_out("post_rst", 316, -317, 1, acc);
    chk("post_rst_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
